// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and default width.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cmp_pkg;

  // Default operand width; legal range is 2..32.
  localparam int CMP_WIDTH_DEFAULT = 8;

  // Controller states; the encoding is fixed so it can be observed in a debugger.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_e;

  // Bits needed to hold a down-counter loaded with w-1 (at least one bit).
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_mag_comparator_cell.sv
// 1-bit equality cell: flags whether the current bit pair matches.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the output is meaningful.
module serial_mag_comparator_cell (
  input  logic a_i,
  input  logic b_i,
  output logic a_eb_b_o
);

  assign a_eb_b_o = ~(a_i ^ b_i);

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit pair per cycle.
// Latency: WIDTH compare cycles after the accept edge; with SERIAL_CMP_EARLY_EXIT_EN defined, stops at the first unequal bit.
// Backpressure: result held stable in DONE until out_ready; in_ready only in IDLE (one bubble per operation).
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             busy
);

  localparam int CW = cnt_bits(WIDTH);

  cmp_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             gt_acc_q, gt_acc_d;

  logic             a_msb;
  logic             b_msb;
  logic             bit_eq;
  logic             first_diff;

  assign a_msb = a_sh_q[WIDTH-1];
  assign b_msb = b_sh_q[WIDTH-1];

  // The cell always looks at the current head of both shift registers.
  serial_mag_comparator_cell u_cell (
    .a_i      (a_msb),
    .b_i      (b_msb),
    .a_eb_b_o (bit_eq)
  );

  // Only the first mismatching bit decides; everything after it is ignored.
  assign first_diff = ~decided_q & ~bit_eq;

  // Next-state and datapath update: capture on accept, shift/decide in COMPARE, hold in DONE.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_acc_d  = gt_acc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          cnt_d     = CW'(WIDTH - 1);
          decided_d = 1'b0;
          gt_acc_d  = 1'b0;
          state_d   = COMPARE;
        end
      end

      COMPARE: begin
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CW'(1);
        if (first_diff) begin
          decided_d = 1'b1;
          gt_acc_d  = a_msb & ~b_msb;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if ((cnt_q == '0) || first_diff) begin
          state_d = DONE;
        end
`else
        if (cnt_q == '0) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_acc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_acc_q  <= gt_acc_d;
    end
  end

  // Outputs decode only registered state, so nothing flows combinationally from the inputs.
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == COMPARE);
  assign out_valid = (state_q == DONE);
  assign a_eq_b    = out_valid & ~decided_q;
  assign a_gt_b    = out_valid &  decided_q &  gt_acc_q;
  assign a_lt_b    = out_valid &  decided_q & ~gt_acc_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench for serial_mag_comparator (WIDTH=8): directed cases plus random traffic.
// Latencies below count the accept edge as edge 1.
// Honours SERIAL_CMP_EARLY_EXIT_EN when the build defines it.
module tb_serial_mag_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic         a_gt_b;
  logic         a_eq_b;
  logic         a_lt_b;
  logic         busy;

  int total = 0;
  int bad   = 0;

  serial_mag_comparator #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_gt_b    (a_gt_b),
    .a_eq_b    (a_eq_b),
    .a_lt_b    (a_lt_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 1-based MSB-first position of the first differing bit; W when the operands are equal.
  function automatic int first_diff_pos(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
    return W;
  endfunction

  // ---------------- behavioural model ----------------
  // m_rdy: ready for a new pair; m_ov: result on offer; m_left: compare cycles still to run.
  bit m_rdy  = 1'b1;
  bit m_ov   = 1'b0;
  int m_left = 0;
  bit m_gt   = 1'b0;
  bit m_eq   = 1'b0;
  bit m_lt   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy = 1'b1; m_ov = 1'b0; m_left = 0;
      m_gt = 1'b0; m_eq = 1'b0; m_lt = 1'b0;
    end else if (m_ov) begin
      if (out_ready) begin
        m_ov  = 1'b0;
        m_rdy = 1'b1;
      end
    end else if (m_rdy) begin
      if (in_valid) begin
        m_rdy = 1'b0;
        m_gt  = (a > b);
        m_eq  = (a == b);
        m_lt  = (a < b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        m_left = first_diff_pos(a, b);
`else
        m_left = W;
`endif
      end
    end else begin
      m_left--;
      if (m_left == 0) m_ov = 1'b1;
    end
  end

  // Every falling edge: DUT outputs against the model.
  always @(negedge clk) begin
    chk("in_ready",  in_ready,  m_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("busy",      busy,      !m_rdy && !m_ov);
    chk("a_gt_b",    a_gt_b,    m_ov && m_gt);
    chk("a_eq_b",    a_eq_b,    m_ov && m_eq);
    chk("a_lt_b",    a_lt_b,    m_ov && m_lt);
  end

  // Caller positions time just after a rising edge; the next edge must accept the pair.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_lat, input string tag);
    int lat;
    lat = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) in_valid = 1'b0;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
  endtask

  task automatic chk_outputs_idle(input string tag);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " busy"},      busy,      1'b0);
    chk({tag, " in_ready"},  in_ready,  1'b1);
    chk({tag, " flags"},     {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           sel;
    int           lat;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset state.
    #1;
    chk_outputs_idle("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Equal operands, accepted on the first edge after reset release.
    run_op(8'hA5, 8'hA5, 9, "eq_A5");
    chk("eq_A5 flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b010);

    // MSB decides.
    @(posedge clk); #2;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    run_op(8'h80, 8'h7F, 2, "gt_80");
`else
    run_op(8'h80, 8'h7F, 9, "gt_80");
`endif
    chk("gt_80 flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b100);

    // Less-than with the consumer stalling for 5 cycles.
    @(posedge clk); #2;
    out_ready = 1'b0;
    run_op(8'h00, 8'h01, 9, "lt_01");
    chk("lt_01 flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall flags",     {a_gt_b, a_eq_b, a_lt_b}, 3'b001);
      chk("stall out_valid", out_valid, 1'b1);
      chk("stall in_ready",  in_ready,  1'b0);
    end
    out_ready = 1'b1;

    // Reset during the 4th compare cycle discards the operation.
    @(posedge clk); @(posedge clk); #2;
    in_valid = 1'b1; a = 8'h3C; b = 8'h3D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_outputs_idle("mid_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("post_reset out_valid", out_valid, 1'b0);
      chk("post_reset in_ready",  in_ready,  1'b1);
    end

    // New pair held on in_valid during COMPARE is taken only after the handshake.
    @(posedge clk); #2;
    in_valid = 1'b1; a = 8'h10; b = 8'h20;
    lat = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin a = 8'hF0; b = 8'h0F; end
      if (out_valid) begin lat = n; break; end
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    chk("hold latency", lat, 4);
`else
    chk("hold latency", lat, 9);
`endif
    chk("hold first flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b001);
    @(posedge clk); #1;
    chk("bubble in_ready", in_ready, 1'b1);
    chk("bubble busy",     busy,     1'b0);
    @(posedge clk); #1;
    chk("second accept busy", busy, 1'b1);
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    chk("second pending", (lat > 0), 1'b1);
    chk("second flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b100);

    // Random traffic with stalls and occasional resets, checked by the model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      ra  = W'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      rb = ra;
      else if (sel == 1) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      else               rb = W'($urandom);
      a         = ra;
      b         = rb;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    @(posedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
